// File: rtl/draw_source_sequencer_pkg.sv
// Shared draw-bus definitions: framebuffer geometry, colour depth, source-select
// encoding and the sequencer state type. Imported by the sequencer and every draw source.
package draw_source_sequencer_pkg;

  localparam int unsigned DRAW_WIDTH        = 320;
  localparam int unsigned DRAW_HEIGHT       = 240;
  localparam int unsigned DRAW_WIDTH_ADDRW  = $clog2(DRAW_WIDTH);
  localparam int unsigned DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT);
  localparam int unsigned COLOR_DEPTH       = 9;

  // One spare code above the largest source ID marks "no source granted".
  localparam int unsigned SOURCE_SEL_ADDRW = 3;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SEL_IDLE = '1;

  localparam int unsigned FB_PIXELS = DRAW_WIDTH * DRAW_HEIGHT;
  localparam int unsigned FB_ADDRW  = $clog2(FB_PIXELS);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSelect,
    StAwait,
    StDrain,
    StNext,
    StDone
  } dss_state_e;

endpackage

// File: rtl/draw_pixel_writer.sv
// Output stage of the draw sequencer: filters bus samples, linearises (x, y) and
// registers the framebuffer write; clear requests take priority over samples.
module draw_pixel_writer
  import draw_source_sequencer_pkg::*;
#(
  parameter logic [COLOR_DEPTH-1:0] BgColor = '0
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         sample_i,
  input  logic                         clear_i,
  input  logic [FB_ADDRW-1:0]          clear_addr_i,
  input  logic [COLOR_DEPTH-1:0]       color_i,
  input  logic                         transparent_i,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  x_i,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] y_i,
  output logic                         fb_we_o,
  output logic [FB_ADDRW-1:0]          fb_addr_o,
  output logic [COLOR_DEPTH-1:0]       fb_data_o
);

  localparam logic [DRAW_WIDTH_ADDRW-1:0]  XLim = DRAW_WIDTH_ADDRW'(DRAW_WIDTH);
  localparam logic [DRAW_HEIGHT_ADDRW-1:0] YLim = DRAW_HEIGHT_ADDRW'(DRAW_HEIGHT);

  logic                   we_d, we_q;
  logic [FB_ADDRW-1:0]    addr_d, addr_q;
  logic [COLOR_DEPTH-1:0] data_d, data_q;
  logic [FB_ADDRW-1:0]    lin_addr;

  assign lin_addr = FB_ADDRW'(y_i) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(x_i);

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (clear_i) begin
      we_d   = 1'b1;
      addr_d = clear_addr_i;
      data_d = BgColor;
    end else if (sample_i && !transparent_i && (x_i < XLim) && (y_i < YLim)) begin
      we_d   = 1'b1;
      addr_d = lin_addr;
      data_d = color_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign fb_we_o   = we_q;
  assign fb_addr_o = addr_q;
  assign fb_data_o = data_q;

endmodule

// File: rtl/draw_source_sequencer.sv
// Per-frame draw sequencer: optional framebuffer clear, then grants the shared write
// bus to each source in painter's order and forwards accepted pixels to the back buffer.
module draw_source_sequencer
  import draw_source_sequencer_pkg::*;
#(
  parameter int unsigned            SOURCE_COUNT  = 4,
  parameter bit                     CLEAR_EN      = 1'b1,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR      = '0,
  parameter int unsigned            AWAIT_TIMEOUT = 4095
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start_i,
  output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel_o,
  output logic                         write_awaited_o,
  input  logic                         write_active_i,
  input  logic [COLOR_DEPTH-1:0]       write_color_data_i,
  input  logic                         write_transparent_i,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr_i,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr_i,
  output logic                         fb_we_o,
  output logic [FB_ADDRW-1:0]          fb_addr_o,
  output logic [COLOR_DEPTH-1:0]       fb_data_o,
  output logic                         frame_done_o,
  output logic                         frame_overrun_o,
  output logic [SOURCE_COUNT-1:0]      skipped_mask_o
);

  localparam int unsigned WaitW = $clog2(AWAIT_TIMEOUT + 1);
  localparam logic [WaitW-1:0]            WaitLast  = WaitW'(AWAIT_TIMEOUT - 1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] SrcLast   = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);
  localparam logic [FB_ADDRW-1:0]         ClearLast = FB_ADDRW'(FB_PIXELS - 1);

  dss_state_e                  state_d, state_q;
  logic [SOURCE_SEL_ADDRW-1:0] src_d, src_q;
  logic [WaitW-1:0]            wait_d, wait_q;
  logic [FB_ADDRW-1:0]         clr_d, clr_q;
  logic [SOURCE_COUNT-1:0]     skipped_d, skipped_q;
  logic                        overrun_q;
  logic                        sample, clear_req;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    wait_d    = wait_q;
    clr_d     = clr_q;
    skipped_d = skipped_q;
    sample    = 1'b0;
    clear_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start_i) begin
          skipped_d = '0;
          src_d     = '0;
          clr_d     = '0;
          state_d   = CLEAR_EN ? StClear : StSelect;
        end
      end
      StClear: begin
        clear_req = 1'b1;
        if (clr_q == ClearLast) state_d = StSelect;
        else                    clr_d   = clr_q + 1'b1;
      end
      StSelect: begin
        wait_d  = '0;
        state_d = StAwait;
      end
      StAwait: begin
        // An x/z on write_active takes the else branches, i.e. counts as not-1.
        if (write_active_i) begin
          sample  = 1'b1;
          state_d = StDrain;
        end else if (wait_q == WaitLast) begin
          skipped_d = skipped_q | (SOURCE_COUNT'(1) << src_q);
          state_d   = StNext;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDrain: begin
        if (write_active_i) sample  = 1'b1;
        else                state_d = StNext;
      end
      StNext: begin
        if (src_q == SrcLast) begin
          state_d = StDone;
        end else begin
          src_d   = src_q + 1'b1;
          state_d = StSelect;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= StIdle;
      src_q     <= '0;
      wait_q    <= '0;
      clr_q     <= '0;
      skipped_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      wait_q    <= wait_d;
      clr_q     <= clr_d;
      skipped_q <= skipped_d;
      overrun_q <= frame_start_i && (state_q != StIdle);
    end
  end

  always_comb begin
    write_source_sel_o = SEL_IDLE;
    if (state_q inside {StSelect, StAwait, StDrain, StNext}) write_source_sel_o = src_q;
  end

  assign write_awaited_o = (state_q == StAwait);
  assign frame_done_o    = (state_q == StDone);
  assign frame_overrun_o = overrun_q;
  assign skipped_mask_o  = skipped_q;

  draw_pixel_writer #(
    .BgColor(BG_COLOR)
  ) u_writer (
    .clk          (clk),
    .resetN       (resetN),
    .sample_i     (sample),
    .clear_i      (clear_req),
    .clear_addr_i (clr_q),
    .color_i      (write_color_data_i),
    .transparent_i(write_transparent_i),
    .x_i          (write_x_addr_i),
    .y_i          (write_y_addr_i),
    .fb_we_o      (fb_we_o),
    .fb_addr_o    (fb_addr_o),
    .fb_data_o    (fb_data_o)
  );

endmodule

// File: tb/tb_draw_source_sequencer.sv
// Scoreboard bench: u_clr exercises the full-frame clear path, u_dut the source
// handoff, filtering, overrun and mid-burst reset behaviour.
module tb_draw_source_sequencer;
  import draw_source_sequencer_pkg::*;

  typedef struct {int addr; int data; int cyc;} exp_t;
  typedef struct {int x; int y; int c; bit tr;} pix_t;

  localparam logic [8:0] BG = 9'h0A5;
  localparam int N = 320 * 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  exp_t cq[$], dq[$];
  int   oq[$];
  pix_t pix_q[$];
  logic [8:0] shadow [int];

  logic c_rst_n = 1'b0, c_start = 1'b0;
  logic [2:0] c_sel; logic c_await, c_we, c_done, c_ovr;
  logic [16:0] c_addr; logic [8:0] c_data; logic [3:0] c_skip;

  logic d_rst_n = 1'b0, d_start = 1'b0, d_active = 1'b0, d_tr = 1'b0;
  logic [8:0] d_color = '0, d_x = '0; logic [7:0] d_y = '0;
  logic [2:0] d_sel; logic d_await, d_we, d_done, d_ovr;
  logic [16:0] d_addr; logic [8:0] d_data; logic [3:0] d_skip;

  draw_source_sequencer #(.SOURCE_COUNT(4), .CLEAR_EN(1'b1), .BG_COLOR(BG), .AWAIT_TIMEOUT(8)) u_clr (
    .clk(clk), .resetN(c_rst_n), .frame_start_i(c_start),
    .write_source_sel_o(c_sel), .write_awaited_o(c_await), .write_active_i(1'b0),
    .write_color_data_i(9'h000), .write_transparent_i(1'b0), .write_x_addr_i(9'h000),
    .write_y_addr_i(8'h00), .fb_we_o(c_we), .fb_addr_o(c_addr), .fb_data_o(c_data),
    .frame_done_o(c_done), .frame_overrun_o(c_ovr), .skipped_mask_o(c_skip)
  );

  draw_source_sequencer #(.SOURCE_COUNT(4), .CLEAR_EN(1'b0), .BG_COLOR(BG), .AWAIT_TIMEOUT(8)) u_dut (
    .clk(clk), .resetN(d_rst_n), .frame_start_i(d_start),
    .write_source_sel_o(d_sel), .write_awaited_o(d_await), .write_active_i(d_active),
    .write_color_data_i(d_color), .write_transparent_i(d_tr), .write_x_addr_i(d_x),
    .write_y_addr_i(d_y), .fb_we_o(d_we), .fb_addr_o(d_addr), .fb_data_o(d_data),
    .frame_done_o(d_done), .frame_overrun_o(d_ovr), .skipped_mask_o(d_skip)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_write(input string name, input exp_t e, input logic [31:0] a,
                             input logic [31:0] d);
    total++;
    if (a !== e.addr || d !== e.data || cyc != e.cyc) begin
      bad++;
      $display("FAIL %s actual addr=%0d data=%0h cyc=%0d required addr=%0d data=%0h cyc=%0d",
               name, a, d, cyc, e.addr, e.data, e.cyc);
    end
  endtask

  // Monitor: every presented write is popped from its scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (c_we === 1'b1) begin
      check("clr_write_expected", cq.size() != 0, 1);
      if (cq.size() != 0) begin e = cq.pop_front(); check_write("clr_write", e, c_addr, c_data); end
    end
    if (d_we === 1'b1) begin
      check("dut_write_expected", dq.size() != 0, 1);
      if (dq.size() != 0) begin e = dq.pop_front(); check_write("dut_write", e, d_addr, d_data); end
      shadow[int'(d_addr)] = d_data;
    end
    if (d_ovr === 1'b1) begin
      check("dut_overrun_expected", oq.size() != 0, 1);
      if (oq.size() != 0) check("dut_overrun_cycle", cyc, oq.pop_front());
    end
    if (c_ovr === 1'b1) check("clr_overrun_never", c_ovr, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit on_clr, input int limit, output int at);
    int t = 0;
    while ((on_clr ? c_done : d_done) !== 1'b1 && t < limit) begin tick(); t++; end
    check(on_clr ? "clr_done_seen" : "dut_done_seen", t < limit, 1);
    at = cyc;
  endtask

  // Source model: wait for the grant, then stream the queued pixels back-to-back.
  task automatic serve(input int id, input int ovr_at);
    int t = 0;
    pix_t p;
    while (!(d_await === 1'b1 && d_sel === 3'(id)) && t < 200) begin tick(); t++; end
    check($sformatf("await_src%0d", id), t < 200, 1);
    if (t >= 200) begin pix_q.delete(); return; end
    for (int i = 0; pix_q.size() > 0; i++) begin
      p = pix_q.pop_front();
      d_active = 1'b1; d_x = 9'(p.x); d_y = 8'(p.y); d_color = 9'(p.c); d_tr = p.tr;
      if (!p.tr && p.x < 320 && p.y < 240) dq.push_back('{p.y * 320 + p.x, p.c, cyc + 1});
      if (i == ovr_at) begin d_start = 1'b1; oq.push_back(cyc + 1); end
      tick();
      d_start = 1'b0;
    end
    d_active = 1'b0; d_tr = 1'b0;
  endtask

  // Start a clearing frame, let n clear writes out, then abort it with reset.
  task automatic clear_burst(input int n);
    int k;
    k = cyc;
    c_start = 1'b1;
    for (int i = 0; i < n; i++) cq.push_back('{i, BG, k + 2 + i});
    tick();
    c_start = 1'b0;
    repeat (n) tick();
    c_rst_n = 1'b0;
    tick();
    check("clr_rst_we", c_we, 0);
    check("clr_rst_sel", c_sel, 3'b111);
    check("clr_rst_done", c_done, 0);
    c_rst_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, at;
    repeat (3) tick();
    check("rst_c_sel", c_sel, 3'b111);
    check("rst_d_sel", d_sel, 3'b111);
    check("rst_c_skip", c_skip, 0);
    check("rst_d_done", d_done, 0);
    check("rst_d_ovr", d_ovr, 0);
    c_rst_n = 1'b1; d_rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_sel", c_sel, 3'b111);
      check("idle_await", c_await, 0);
      check("idle_we", c_we, 0);
      check("idle_d_we", d_we, 0);
    end

    // Full clear frame with every source idle.
    k = cyc;
    c_start = 1'b1;
    for (int i = 0; i < N; i++) cq.push_back('{i, BG, k + 2 + i});
    tick();
    c_start = 1'b0;
    wait_done(1'b1, N + 200, at);
    check("clr_done_cycle", at, k + N + 41);
    check("clr_skipped", c_skip, 4'b1111);
    check("clr_queue_empty", cq.size(), 0);
    tick();
    check("clr_done_pulse", c_done, 0);
    check("clr_sel_after", c_sel, 3'b111);

    // Reset mid-clear, then a new frame restarts the clear at address 0.
    clear_burst(19);
    clear_burst(10);
    check("clr_burst_queue_empty", cq.size(), 0);

    // Painter's-order frame: src0, src1 (with filtered samples and overrun), src2, src3 idle.
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    check("dut_select_src0", d_sel, 0);
    check("dut_select_await0", d_await, 0);
    pix_q.push_back('{10, 10, 'h049, 1'b0});
    serve(0, -1);
    pix_q.push_back('{5, 7, 'h1FF, 1'b0});
    pix_q.push_back('{400, 7, 'h111, 1'b0});
    pix_q.push_back('{5, 8, 'h0F0, 1'b1});
    serve(1, 1);
    pix_q.push_back('{10, 10, 'h1C0, 1'b0});
    serve(2, -1);
    wait_done(1'b0, 100, at);
    check("dut_skipped", d_skip, 4'b1000);
    tick();
    check("dut_done_pulse", d_done, 0);
    check("dut_queue_empty", dq.size(), 0);
    check("dut_overrun_queue_empty", oq.size(), 0);
    check("fb_3210", shadow.exists(3210) ? int'(shadow[3210]) : -1, 'h1C0);
    check("fb_2245", shadow.exists(2245) ? int'(shadow[2245]) : -1, 'h1FF);
    check("fb_2565_untouched", shadow.exists(2565), 0);

    // Reset in the middle of a drain burst.
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    pix_q.push_back('{1, 1, 'h0AA, 1'b0});
    pix_q.push_back('{2, 1, 'h0AB, 1'b0});
    serve(0, -1);
    d_active = 1'b1; d_x = 9'd3; d_y = 8'd1; d_color = 9'h0AC;
    d_rst_n = 1'b0;
    tick();
    check("drain_rst_sel", d_sel, 3'b111);
    check("drain_rst_we", d_we, 0);
    check("drain_rst_await", d_await, 0);
    check("drain_rst_done", d_done, 0);
    d_rst_n = 1'b1; d_active = 1'b0;
    tick();
    check("drain_rst_still_idle", d_sel, 3'b111);
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    check("restart_sel0", d_sel, 0);
    check("restart_await0", d_await, 0);
    tick();
    check("restart_await1", d_await, 1);
    wait_done(1'b0, 100, at);
    check("restart_skipped", d_skip, 4'b1111);
    tick();
    check("final_dut_queue_empty", dq.size(), 0);
    check("fb_321", shadow.exists(321) ? int'(shadow[321]) : -1, 'h0AA);
    check("fb_323_untouched", shadow.exists(323), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
